// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display scheduler.
// Holds the value/BCD widths, the special digit codes, the scheduler state
// enum, one double-dabble step and the digit formatting (over-range and
// leading-zero blanking) used by the scheduler.
package seg7_pkg;

    localparam int VALUE_W     = 14;
    localparam int BCD_W       = 16;
    localparam int MAX_DISPLAY = 9999;
    localparam int CONV_STEPS  = 14;

    localparam logic [3:0] BCD_ERR   = 4'd10;
    localparam logic [3:0] BCD_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } sched_state_t;

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}:
    // add 3 to every BCD nibble that is 5 or more, then shift left by one.
    function automatic logic [BCD_W+VALUE_W-1:0] dd_step(input logic [BCD_W+VALUE_W-1:0] sr);
        logic [BCD_W+VALUE_W-1:0] t;
        t = sr;
        for (int k = 0; k < 4; k++) begin
            if (t[VALUE_W+4*k +: 4] >= 4'd5) begin
                t[VALUE_W+4*k +: 4] = t[VALUE_W+4*k +: 4] + 4'd3;
            end else begin
                t[VALUE_W+4*k +: 4] = t[VALUE_W+4*k +: 4];
            end
        end
        return {t[BCD_W+VALUE_W-2:0], 1'b0};
    endfunction

    // Turns raw BCD {d3,d2,d1,d0} into display codes. Over-range shows "E   ".
    // With blanking, zeros left of the most significant nonzero digit are
    // blanked; digit 0 is always shown.
    function automatic logic [15:0] format_digits(input logic [15:0] bcd,
                                                  input logic        over,
                                                  input logic        lz);
        logic [15:0] r;
        r = bcd;
        if (over) begin
            r = {BCD_ERR, BCD_BLANK, BCD_BLANK, BCD_BLANK};
        end else if (lz) begin
            if (r[15:12] == 4'd0) begin
                r[15:12] = BCD_BLANK;
                if (r[11:8] == 4'd0) begin
                    r[11:8] = BCD_BLANK;
                    if (r[7:4] == 4'd0) begin
                        r[7:4] = BCD_BLANK;
                    end else begin
                        r[7:4] = r[7:4];
                    end
                end else begin
                    r[11:8] = r[11:8];
                end
            end else begin
                r[15:12] = r[15:12];
            end
        end else begin
            r = bcd;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_display_scheduler_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble).
// The first step is applied on the start edge itself, so after 14 edges
// (start edge + 13) the result is complete and done pulses for one cycle.
// Ports: clk, rst_n (async, active-low), srst (synchronous abort),
//        start, din[13:0] -> busy, done (1-cycle pulse), bcd[15:0] {d3,d2,d1,d0}.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srst,
    input  logic               start,
    input  logic [VALUE_W-1:0] din,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic [BCD_W+VALUE_W-1:0] sr_r;
    logic [3:0]               cnt_r;
    logic                     busy_r;
    logic                     done_r;

    // Shift register, step counter and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r   <= '0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (srst) begin
            sr_r   <= '0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            sr_r   <= dd_step({{BCD_W{1'b0}}, din});
            cnt_r  <= 4'd1;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            sr_r <= dd_step(sr_r);
            if (cnt_r == 4'(CONV_STEPS - 1)) begin
                cnt_r  <= 4'd0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + 4'd1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = sr_r[BCD_W+VALUE_W-1:VALUE_W];

endmodule

// File: rtl/seg7_display_scheduler.sv
// Shares a 4-digit seven-segment display between NUM_REQ requesters.
// Fixed-priority grant (index 0 highest), sequential BCD conversion,
// minimum dwell per shown message, over-range 'E' and leading-zero blanking.
// Ports: clk, rst_n (async, active-low), req[NUM_REQ], value[NUM_REQ*14],
//        clear (pulse) -> ack[NUM_REQ] (one-hot pulse), busy, src_id, valid,
//        bcd_data_0..3 (digit 0 rightmost; 0-9, 10='E', 15=blank).
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DWELL_CYCLES = 50000000,
    parameter int LZ_BLANK     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*VALUE_W-1:0]   value,
    input  logic                         clear,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   src_id,
    output logic                         valid,
    output logic [3:0]                   bcd_data_0,
    output logic [3:0]                   bcd_data_1,
    output logic [3:0]                   bcd_data_2,
    output logic [3:0]                   bcd_data_3
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int DW_W = $clog2(DWELL_CYCLES + 1);

    sched_state_t        state_r;
    sched_state_t        state_next_s;
    logic [DW_W-1:0]     dwell_r;
    logic                dwell_sat_s;
    logic                grant_s;
    logic [ID_W-1:0]     gnt_id_s;
    logic [VALUE_W-1:0]  gnt_val_s;
    logic [ID_W-1:0]     cap_id_r;
    logic                over_r;
    logic                conv_busy_s;
    logic                conv_done_s;
    logic [BCD_W-1:0]    conv_bcd_s;

    assign dwell_sat_s = (dwell_r == DW_W'(DWELL_CYCLES));

    // Lowest set request index wins; its value is selected alongside.
    always_comb begin
        gnt_id_s  = '0;
        gnt_val_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_id_s  = ID_W'(i);
                gnt_val_s = value[i*VALUE_W +: VALUE_W];
            end else begin
                gnt_id_s  = gnt_id_s;
                gnt_val_s = gnt_val_s;
            end
        end
    end

    // A grant happens from IDLE, or from SHOW once the dwell has elapsed; clear wins.
    always_comb begin
        grant_s = 1'b0;
        if (clear || (req == '0)) begin
            grant_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    grant_s = 1'b1;
                SHOW:    grant_s = dwell_sat_s;
                default: grant_s = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = grant_s ? CONVERT : IDLE;
                end
                CONVERT: begin
                    // A converter that is neither running nor finishing means the
                    // conversion was lost; fall back to IDLE instead of hanging.
                    if (conv_done_s) begin
                        state_next_s = SHOW;
                    end else if (!conv_busy_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = CONVERT;
                    end
                end
                SHOW: begin
                    state_next_s = grant_s ? CONVERT : SHOW;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Registered outputs, capture of the granted request and the dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= '0;
            busy       <= 1'b0;
            src_id     <= '0;
            valid      <= 1'b0;
            bcd_data_0 <= BCD_BLANK;
            bcd_data_1 <= BCD_BLANK;
            bcd_data_2 <= BCD_BLANK;
            bcd_data_3 <= BCD_BLANK;
            dwell_r    <= '0;
            cap_id_r   <= '0;
            over_r     <= 1'b0;
        end else begin
            busy <= (state_next_s == CONVERT);
            if (clear) begin
                ack        <= '0;
                valid      <= 1'b0;
                bcd_data_0 <= BCD_BLANK;
                bcd_data_1 <= BCD_BLANK;
                bcd_data_2 <= BCD_BLANK;
                bcd_data_3 <= BCD_BLANK;
                dwell_r    <= '0;
            end else if (grant_s) begin
                ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_s;
                cap_id_r <= gnt_id_s;
                over_r   <= (gnt_val_s > VALUE_W'(MAX_DISPLAY));
            end else if ((state_r == CONVERT) && conv_done_s) begin
                ack <= '0;
                {bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0} <=
                    format_digits(conv_bcd_s, over_r, (LZ_BLANK != 0));
                src_id  <= cap_id_r;
                valid   <= 1'b1;
                dwell_r <= '0;
            end else begin
                ack <= '0;
                if ((state_r == SHOW) && !dwell_sat_s) begin
                    dwell_r <= dwell_r + DW_W'(1);
                end else begin
                    dwell_r <= dwell_r;
                end
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (clear),
        .start (grant_s),
        .din   (gnt_val_s),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

endmodule

// File: doc/seg7_display_scheduler.md
Name: seg7_display_scheduler

Overview:
- Shares the 4-digit seven-segment display between NUM_REQ requesters, e.g. matrix-result value, operation code and error counter.
- Arbitrates requests by fixed priority and converts the winner's binary value to BCD with a sequential double-dabble.
- Enforces a minimum dwell time per message, applies leading-zero blanking and over-range marking.
- Drives the valid/bcd_data_0..3 inputs of the seven-segment scan driver.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has highest priority.
- DWELL_CYCLES, 50000000, minimum clk cycles a shown message is held before another request is granted; must be ≥1.
- LZ_BLANK, 1, 1 = blank leading zeros (digit 0 is never blanked); 0 = show all zeros.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until its ack.
- value  in  NUM_REQ*14  packed binary values; requester i uses bits [14*i+13:14*i].
- clear  in  1  single-cycle pulse: blank the display and abort any activity.
- ack  out  NUM_REQ  one-hot, one-cycle pulse when that requester's value is captured.
- busy  out  1  high in CONVERT.
- src_id  out  $clog2(NUM_REQ)  requester currently shown; held while a conversion runs.
- valid  out  1  display enable to the scan driver.
- bcd_data_0..bcd_data_3  out  4 each  digit codes; 0 is the rightmost digit; 0-9 digit, 10 'E', 15 blank.

Behaviour:
- Reset values:
  - Outputs: ack=0, busy=0, src_id=0, valid=0, all bcd_data=15.
  - Internal: state=IDLE, dwell counter=0.
- FSM states IDLE, CONVERT, SHOW. All outputs are registered.
- IDLE:
  - If req≠0 at an edge: grant the lowest set index g, capture value[g] and g, pulse ack[g] in the next cycle, go to CONVERT.
- CONVERT: one double-dabble step per cycle for 14 cycles.
  - On the 14th edge after the grant edge: load bcd_data_0..3, src_id=g, valid=1, clear the dwell counter, go to SHOW.
  - Grant-to-display latency is exactly 14 cycles.
  - Displayed digits, valid and src_id keep their previous values during CONVERT; the display must not flicker.
  - req changes are ignored during CONVERT.
- SHOW:
  - The dwell counter increments and saturates at DWELL_CYCLES.
  - Before saturation, req is ignored and no ack is issued.
  - After saturation, any req ≠0 triggers a grant exactly as in IDLE, and the old digits remain until the new load.
  - With no req, the message is held indefinitely.
  - The same requester may be re-granted.
- Over-range: a captured value >9999 displays digit3=10, digits2..0=15 after the normal 14-cycle latency.
- Leading-zero blanking (LZ_BLANK=1): every zero digit to the left of the most significant nonzero digit becomes 15; value 0 shows digits 15,15,15,0.
- clear:
  - In any state, next edge: valid=0, all bcd_data=15, dwell counter=0, state=IDLE.
  - Any conversion is aborted and no ack is issued in that cycle.
  - clear beats a simultaneous req; the req is granted on the following edge if still high.
- A req dropped before its ack is simply not served. A req still high after its ack is treated as a new request.
- Asynchronous reset mid-CONVERT discards the conversion and restores all reset values immediately.

Decomposition:
- Shared package seg7_pkg:
  - VALUE_W=14, MAX_DISPLAY=9999, CONV_STEPS=14.
  - BCD_ERR=4'd10, BCD_BLANK=4'd15.
  - Enum sched_state_t {IDLE, CONVERT, SHOW}.
- One sub-module: bin2bcd_seq.
  - start/busy/done handshake; 14-bit in, 4×4-bit BCD out; 14-cycle sequential double-dabble.
  - The over-range check and blanking stay in the scheduler.

Test Plan:
- Reset, then req[1] with value1=1234 → ack[1] one cycle after the grant edge; 14 cycles later bcd3..0=1,2,3,4, valid=1, src_id=1.
- value0=7 with LZ_BLANK=1 → 15,15,15,7; rerun with LZ_BLANK=0 → 0,0,0,7; value0=0 → 15,15,15,0.
- value2=12000 → bcd3..0=10,15,15,15 with valid=1.
- req[0] and req[2] asserted together (values 11 and 22) → ack[0] first and 11 shown. With DWELL_CYCLES=20, req[2] gets no ack before 20 SHOW cycles, then is granted and 22 is shown 14 cycles later.
- clear pulsed mid-CONVERT → next cycle valid=0, all digits 15, no ack; a later req is served normally.
- rst_n deasserted asynchronously mid-CONVERT → outputs return to reset values without waiting for a clock edge; after release, value1=9999 displays 9,9,9,9.
